mem_line_responder: RTL



---
 rtl/mem_line_responder_pkg.sv | 25 ++
 rtl/vc_CombinationalSRAM_1rw.sv | 31 +++
 rtl/mem_line_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared 16B memory message formats and request type codes used by the
// line responder and the cache that drives it.
package mem_line_responder_pkg;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  localparam logic [2:0] c_mem_type_read  = 3'd0;
  localparam logic [2:0] c_mem_type_write = 3'd1;
  localparam logic [2:0] c_mem_type_init  = 3'd2;

endpackage

// File: rtl/vc_CombinationalSRAM_1rw.sv
// Single-port line store: combinational read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module vc_CombinationalSRAM_1rw #(
  parameter int p_data_nbits  = 128,
  parameter int p_num_entries = 256,
  localparam int c_addr_nbits = $clog2(p_num_entries),
  localparam int c_nbytes     = (p_data_nbits + 7) / 8
) (
  input  logic                    clk,
  input  logic                    read_en,
  input  logic [c_addr_nbits-1:0] read_addr,
  output logic [p_data_nbits-1:0] read_data,
  input  logic                    write_en,
  input  logic [c_nbytes-1:0]     write_byte_en,
  input  logic [c_addr_nbits-1:0] write_addr,
  input  logic [p_data_nbits-1:0] write_data
);

  logic [p_data_nbits-1:0] mem [p_num_entries];

  assign read_data = read_en ? mem[read_addr] : '0;

  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if (write_byte_en[i]) mem[write_addr][i*8 +: 8] <= write_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Line-granularity memory responder: accepts one 16B request at a time and
// answers after a fixed latency, backed by a combinational line store.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreq_val,
  output logic          memreq_rdy,
  input  mem_req_16B_t  memreq_msg,
  output logic          memresp_val,
  input  logic          memresp_rdy,
  output mem_resp_16B_t memresp_msg
);

  localparam int c_idx_w = $clog2(p_num_lines);
  localparam int c_cnt_w = $clog2(p_latency + 1);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_wait = 2'd1,
    st_resp = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  mem_resp_16B_t       resp_q, resp_d;

  logic                accept;
  logic                is_read;
  logic                is_write;
  logic [c_idx_w-1:0]  idx;
  logic [127:0]        store_rdata;
  logic                unused_msg_bits;

  assign idx             = memreq_msg.addr[4 +: c_idx_w];
  assign unused_msg_bits = ^{memreq_msg.addr, memreq_msg.len};

  // Ready in RESP follows memresp_rdy so retire and accept can share an edge.
  assign memreq_rdy = (state_q == st_idle) || ((state_q == st_resp) && memresp_rdy);
  assign accept     = memreq_val && memreq_rdy;
  assign is_read    = memreq_msg.type_ == c_mem_type_read;
  assign is_write   = (memreq_msg.type_ == c_mem_type_write) ||
                      (memreq_msg.type_ == c_mem_type_init);

  vc_CombinationalSRAM_1rw #(128, p_num_lines) u_store (
    .clk           (clk),
    .read_en       (accept && is_read),
    .read_addr     (idx),
    .read_data     (store_rdata),
    .write_en      (accept && is_write),
    .write_byte_en ({16{1'b1}}),
    .write_addr    (idx),
    .write_data    (memreq_msg.data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    memresp_val = 1'b0;

    case (state_q)
      st_idle: ;
      st_wait: begin
        if (cnt_q == c_cnt_w'(1)) begin
          state_d = st_resp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end
      end
      st_resp: begin
        memresp_val = 1'b1;
        if (memresp_rdy) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase

    // A new accept overrides the retire path, whether from IDLE or RESP.
    if (accept) begin
      resp_d.type_  = memreq_msg.type_;
      resp_d.opaque = memreq_msg.opaque;
      resp_d.test   = 2'b00;
      resp_d.len    = 4'd0;
      resp_d.data   = is_read ? store_rdata : 128'd0;
      if (p_latency == 1) begin
        state_d = st_resp;
      end else begin
        state_d = st_wait;
        cnt_d   = c_cnt_w'(p_latency - 1);
      end
    end
  end

  assign memresp_msg = resp_q;

endmodule
